// File: rtl/sdram_tribuf_sched.sv
// Triple-buffer bank scheduler: rotates writer, reader and spare SDRAM banks on frame-done edges.
// Optional FRAME_STATS_EN adds saturating drop/repeat frame counters.
module sdram_tribuf_sched #(
  parameter int unsigned BANK_W      = 2,
  parameter int unsigned RST_WR_BANK = 0,
  parameter int unsigned RST_RD_BANK = 1,
  parameter int unsigned RST_SP_BANK = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bank_valid,
  input  logic              frame_write_done,
  input  logic              frame_read_done,
  output logic [BANK_W-1:0] wr_bank,
  output logic [BANK_W-1:0] rd_bank,
  output logic              wr_load,
  output logic              rd_load,
`ifdef FRAME_STATS_EN
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  repeat_cnt,
`endif
  output logic              spare_fresh
);

  logic [BANK_W-1:0] sp_bank;
  logic              wd_q, rd_q, bv_q;
  logic              we, re, bv_rise;

  logic [BANK_W-1:0] wr_bank_n, rd_bank_n, sp_bank_n;
  logic              spare_fresh_n, wr_load_n, rd_load_n;
  logic              drop_inc, repeat_inc;

  assign we      = frame_write_done & ~wd_q;
  assign re      = frame_read_done & ~rd_q;
  assign bv_rise = bank_valid & ~bv_q;

  // Write swap is applied first so a coincident read picks up the frame just finished.
  always_comb begin
    wr_bank_n     = wr_bank;
    rd_bank_n     = rd_bank;
    sp_bank_n     = sp_bank;
    spare_fresh_n = spare_fresh;
    wr_load_n     = 1'b0;
    rd_load_n     = 1'b0;
    drop_inc      = 1'b0;
    repeat_inc    = 1'b0;
    if (bank_valid) begin
      if (we) begin
        drop_inc      = spare_fresh;
        wr_bank_n     = sp_bank;
        sp_bank_n     = wr_bank;
        spare_fresh_n = 1'b1;
        wr_load_n     = 1'b1;
      end
      if (re) begin
        if (spare_fresh_n) begin
          rd_bank_n     = sp_bank_n;
          sp_bank_n     = rd_bank;
          spare_fresh_n = 1'b0;
        end else begin
          repeat_inc = 1'b1;
        end
        rd_load_n = 1'b1;
      end
      if (bv_rise) begin
        wr_load_n = 1'b1;
        rd_load_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank     <= BANK_W'(RST_WR_BANK);
      rd_bank     <= BANK_W'(RST_RD_BANK);
      sp_bank     <= BANK_W'(RST_SP_BANK);
      spare_fresh <= 1'b0;
      wr_load     <= 1'b0;
      rd_load     <= 1'b0;
      wd_q        <= 1'b0;
      rd_q        <= 1'b0;
      bv_q        <= 1'b0;
    end else begin
      wr_bank     <= wr_bank_n;
      rd_bank     <= rd_bank_n;
      sp_bank     <= sp_bank_n;
      spare_fresh <= spare_fresh_n;
      wr_load     <= wr_load_n;
      rd_load     <= rd_load_n;
      wd_q        <= frame_write_done;
      rd_q        <= frame_read_done;
      bv_q        <= bank_valid;
    end
  end

`ifdef FRAME_STATS_EN
  // Saturating statistics, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt   <= '0;
      repeat_cnt <= '0;
    end else begin
      if (drop_inc && (drop_cnt != {CNT_W{1'b1}}))
        drop_cnt <= drop_cnt + CNT_W'(1);
      if (repeat_inc && (repeat_cnt != {CNT_W{1'b1}}))
        repeat_cnt <= repeat_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_stats;
  assign unused_stats = drop_inc ^ repeat_inc;
`endif

endmodule
